// File: rtl/wb_trace_pkg.sv
// rtl/wb_trace_pkg.sv - shared entry type and field widths for the writeback trace FIFO
package wb_trace_pkg;

    localparam int TRACE_PC_W   = 32;
    localparam int TRACE_WNUM_W = 5;

    typedef struct packed {
        logic [TRACE_PC_W-1:0]   pc;
        logic [3:0]              wen;
        logic [TRACE_WNUM_W-1:0] wnum;
        logic [31:0]             wdata;
    } trace_entry_t;

endpackage

// File: rtl/wb_trace_fifo_sync_fifo.sv
// rtl/wb_trace_fifo_sync_fifo.sv - synchronous FIFO with level output; head reads as zero when empty
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Stale storage never leaks out: the head reads as zero whenever nothing is queued.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - filters writeback trace into a FIFO stream with drop/capture statistics
// Optional: WB_TRACE_STOP_ON_OVF_EN freezes capture after the first dropped event.
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter int  SKIP_R0 = 1,
    parameter int  CNT_W   = 16,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [TRACE_PC_W-1:0]   debug_wb_pc,
    input  logic [3:0]              debug_wb_rf_wen,
    input  logic [TRACE_WNUM_W-1:0] debug_wb_rf_wnum,
    input  logic [31:0]             debug_wb_rf_wdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TRACE_PC_W-1:0]   out_pc,
    output logic [3:0]              out_wen,
    output logic [TRACE_WNUM_W-1:0] out_wnum,
    output logic [31:0]             out_wdata,
    output logic [LW-1:0]           fill_level,
    output logic                    overflow,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic [31:0]             capture_cnt
);

    trace_entry_t in_entry;
    trace_entry_t head;
    logic         trace_event;
    logic         full;
    logic         empty;
    logic         pop;
    logic         push;
    logic         drop;

    assign trace_event = (|debug_wb_rf_wen) && ((SKIP_R0 == 0) || (debug_wb_rf_wnum != '0));

    assign in_entry = '{pc:    debug_wb_pc,
                        wen:   debug_wb_rf_wen,
                        wnum:  debug_wb_rf_wnum,
                        wdata: debug_wb_rf_wdata};

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

`ifdef WB_TRACE_STOP_ON_OVF_EN
    // Once anything is lost, keep the queue as the trace leading up to that loss.
    assign push = trace_event && (!full || pop) && !overflow;
`else
    assign push = trace_event && (!full || pop);
`endif

    assign drop = trace_event && !push;

    sync_fifo #(
        .WIDTH ($bits(trace_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fill_level)
    );

    assign out_pc    = head.pc;
    assign out_wen   = head.wen;
    assign out_wnum  = head.wnum;
    assign out_wdata = head.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow    <= 1'b0;
            drop_cnt    <= '0;
            capture_cnt <= '0;
        end else begin
            if (push) begin
                capture_cnt <= capture_cnt + 32'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
- Consumes the CPU writeback debug trace (pc, rf write-enable, rf write number, rf write data) from soc_lite_top.
- Filters out non-writing retirements and buffers the register-write events in a synchronous FIFO.
- Presents the buffered events on a valid/ready stream for a trace comparator or UART dumper.
- Keeps retire, drop and overflow statistics for post-run inspection.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- SKIP_R0, 1, when 1, writes to r0 are not captured.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- debug_wb_pc  input  32  writeback PC
- debug_wb_rf_wen  input  4  byte write enables; any set bit means a write
- debug_wb_rf_wnum  input  5  destination register number
- debug_wb_rf_wdata  input  32  write data
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer accepts the head entry
- out_pc  output  32  head PC
- out_wen  output  4  head write enables
- out_wnum  output  5  head register number
- out_wdata  output  32  head data
- fill_level  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky; set when any event is dropped
- drop_cnt  output  CNT_W  number of dropped events; saturates
- capture_cnt  output  32  number of events accepted into the FIFO; wraps

Behaviour:
- Reset (synchronous, active-high, sampled at posedge clk):
  - read pointer, write pointer and occupancy return to 0.
  - out_valid, overflow, drop_cnt and capture_cnt are 0.
  - out_* data outputs are 0.
  - Reset overrides a push or pop in the same cycle.
- Event qualification: event = (|debug_wb_rf_wen) && (!SKIP_R0 || debug_wb_rf_wnum != 0). Sampled every posedge; there is no input handshake.
- pop = out_valid && out_ready.
- push = event && (!full || pop). A write into a full FIFO is accepted when a pop happens in the same cycle.
- Latency: an event captured at edge N appears on out_* with out_valid=1 after edge N when the FIFO was empty. There is no combinational bypass.
- out_* always reflect the head entry. They are held stable while out_valid && !out_ready.
- Occupancy:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - full = (fill_level == DEPTH); empty = (fill_level == 0).
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Drop: when event && full && !pop:
  - the event is discarded.
  - drop_cnt increments, saturating at all-ones.
  - overflow is set and stays set until reset.
- capture_cnt increments on every push and wraps modulo 2^32.
- out_ready asserted while empty has no effect.

Optional Feature:
- Macro: WB_TRACE_STOP_ON_OVF_EN
- Defined:
  - after the first drop, push is forced to 0 until reset.
  - Entries already in the FIFO still drain normally.
  - drop_cnt keeps counting every qualified event that is refused.
  - This preserves the trace leading up to the first loss.
- Undefined: capture resumes as soon as space frees.

Decomposition:
- Package wb_trace_pkg:
  - trace_entry_t packed struct: pc[31:0], wen[3:0], wnum[4:0], wdata[31:0]; 73 bits.
  - constants TRACE_PC_W=32 and TRACE_WNUM_W=5.
- Sub-module sync_fifo:
  - parameterised by element width and DEPTH.
  - push/pop/full/empty/level ports; holds the storage and pointers.
- wb_trace_fifo wraps sync_fifo and owns qualification, the counters, overflow and the optional feature.

Test Plan:
- Reset mid-run: fill with 5 events, assert reset for one cycle → fill_level=0, out_valid=0, capture_cnt=0, drop_cnt=0, overflow=0 on the next cycle.
- Filtering: present wen=0xF wnum=0; then wen=0 wnum=3; then wen=0xF wnum=3 pc=0x1c000000 wdata=0x12345678.
  - Only the third is captured.
  - One cycle later out_valid=1, out_pc=0x1c000000, out_wdata=0x12345678.
  - capture_cnt=1.
- Ordering and wrap: out_ready=1, stream 40 events with pc=0x1c000000+4*i → consumer sees all 40 in order; pointers wrap twice; drop_cnt=0.
- Overflow: out_ready=0, 20 consecutive events with DEPTH=16:
  - fill_level=16, drop_cnt=4, overflow=1.
  - Then drain: 16 entries with pc values i=0..15 are seen.
- Full plus simultaneous pop/push: FIFO full, out_ready=1 and event in the same cycle → event accepted, fill_level stays 16, drop_cnt unchanged.
- WB_TRACE_STOP_ON_OVF_EN defined: overflow as above, drain fully, send 3 more events → none captured, drop_cnt=7, out_valid=0.
